// File: rtl/ldo_power_sequencer.sv
// ldo_power_sequencer: Wishbone-controlled up/down sequencer for the user-area 1.8 V LDOs.
// Optional macro LDO_SEQ_IRQ_EN builds the fault interrupt (irq_o) and the CTRL.IE bit.
module ldo_power_sequencer #(
  parameter int          NUM_LDO  = 3,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          DLY_W    = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic [NUM_LDO-1:0] ldo_pg_i,
  output logic [NUM_LDO-1:0] ldo_en_o,
  output logic               irq_o
);
  localparam int IDX_W = (NUM_LDO > 1) ? $clog2(NUM_LDO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LDO - 1);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_UP_PG     = 3'd1,
    S_UP_SETTLE = 3'd2,
    S_ON        = 3'd3,
    S_DN_SETTLE = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_inc, idx_dec;
  logic [NUM_LDO-1:0] en_q, en_d;
  logic [DLY_W-1:0]   timer_q, timer_d, timer_sat;
  logic [DLY_W:0]     timer_inc;
  logic [DLY_W-1:0]   dly_eff;
  logic               fault_q, fault_d;
  logic               settle_done, tmo_done, busy;
  logic [NUM_LDO-1:0] pg_meta_q, pg_sync_q;

  logic               go_q, clr_q, ie;
  logic [DLY_W-1:0]   dly_q, tmo_q;
  logic               ack_q;
  logic [31:0]        dat_q;
  logic               adr_hit, acc, wr, ctrl_wr;
  logic [2:0]         reg_sel;
  logic [31:0]        wmask, dly_wr, tmo_wr, rdata, status;
  logic               unused_bits;

  // ---------------- Wishbone register file ----------------
  assign adr_hit = (wbs_adr_i[31:5] == BASE_ADR[31:5]);
  assign acc     = wbs_stb_i & wbs_cyc_i & ~ack_q & adr_hit;
  assign wr      = acc & wbs_we_i;
  assign reg_sel = wbs_adr_i[4:2];
  assign ctrl_wr = wr && (reg_sel == 3'd0) && wbs_sel_i[0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
    end
  endgenerate

  assign dly_wr      = (32'(dly_q) & ~wmask) | (wbs_dat_i & wmask);
  assign tmo_wr      = (32'(tmo_q) & ~wmask) | (wbs_dat_i & wmask);
  assign unused_bits = ^{wbs_adr_i[1:0], dly_wr, tmo_wr};

  assign busy = (state_q == S_UP_PG) || (state_q == S_UP_SETTLE) || (state_q == S_DN_SETTLE);

  always_comb begin
    status                = '0;
    status[NUM_LDO-1:0]   = en_q;
    status[8 +: NUM_LDO]  = pg_sync_q;
    status[16]            = busy;
    status[17]            = fault_q;
    status[20:18]         = state_q;
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      3'd0:    rdata = {29'd0, ie, 1'b0, go_q};
      3'd1:    rdata = 32'(dly_q);
      3'd2:    rdata = 32'(tmo_q);
      3'd3:    rdata = status;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      go_q  <= 1'b0;
      clr_q <= 1'b0;
      dly_q <= DLY_W'(16'h0100);
      tmo_q <= DLY_W'(16'h1000);
    end else begin
      ack_q <= acc;
      dat_q <= (acc && !wbs_we_i) ? rdata : '0;
      clr_q <= ctrl_wr & wbs_dat_i[1];
      if (ctrl_wr) go_q <= wbs_dat_i[0];
      if (wr && reg_sel == 3'd1) dly_q <= dly_wr[DLY_W-1:0];
      if (wr && reg_sel == 3'd2) tmo_q <= tmo_wr[DLY_W-1:0];
    end
  end

`ifdef LDO_SEQ_IRQ_EN
  logic ie_q, irq_q;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (ctrl_wr) ie_q <= wbs_dat_i[2];
      irq_q <= fault_d & ie_q;
    end
  end
  assign ie    = ie_q;
  assign irq_o = irq_q;
`else
  assign ie    = 1'b0;
  assign irq_o = 1'b0;
`endif

  // ---------------- Power-good synchronizer ----------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pg_meta_q <= '0;
      pg_sync_q <= '0;
    end else begin
      pg_meta_q <= ldo_pg_i;
      pg_sync_q <= pg_meta_q;
    end
  end

  // ---------------- Sequencer FSM ----------------
  // The timer counts cycles since the last step edge; it saturates instead of wrapping.
  assign dly_eff     = (dly_q == '0) ? DLY_W'(1) : dly_q;
  assign timer_inc   = {1'b0, timer_q} + (DLY_W+1)'(1);
  assign timer_sat   = (&timer_q) ? timer_q : timer_inc[DLY_W-1:0];
  assign settle_done = (timer_inc >= {1'b0, dly_eff});
  assign tmo_done    = (tmo_q != '0) && (timer_inc >= {1'b0, tmo_q});
  assign idx_inc     = idx_q + IDX_W'(1);
  assign idx_dec     = idx_q - IDX_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    fault_d = fault_q;
    timer_d = timer_sat;
    case (state_q)
      S_OFF: begin
        en_d = '0;
        if (go_q && !fault_q) begin
          en_d[0] = 1'b1;
          idx_d   = '0;
          timer_d = '0;
          state_d = S_UP_PG;
        end
      end
      S_UP_PG: begin
        if (!go_q) begin
          en_d[idx_q] = 1'b0;
          timer_d     = '0;
          state_d     = S_DN_SETTLE;
        end else if (pg_sync_q[idx_q]) begin
          timer_d = '0;
          state_d = S_UP_SETTLE;
        end else if (tmo_done) begin
          en_d    = '0;
          fault_d = 1'b1;
          state_d = S_FAULT;
        end
      end
      S_UP_SETTLE: begin
        if (!go_q) begin
          en_d[idx_q] = 1'b0;
          timer_d     = '0;
          state_d     = S_DN_SETTLE;
        end else if (settle_done) begin
          timer_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_ON;
          end else begin
            idx_d         = idx_inc;
            en_d[idx_inc] = 1'b1;
            state_d       = S_UP_PG;
          end
        end
      end
      S_ON: begin
        if (|(en_q & ~pg_sync_q)) begin
          en_d    = '0;
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else if (!go_q) begin
          en_d[idx_q] = 1'b0;
          timer_d     = '0;
          state_d     = S_DN_SETTLE;
        end
      end
      S_DN_SETTLE: begin
        if (settle_done) begin
          timer_d = '0;
          if (idx_q == '0) begin
            state_d = S_OFF;
          end else begin
            idx_d         = idx_dec;
            en_d[idx_dec] = 1'b0;
          end
        end
      end
      S_FAULT: begin
        en_d = '0;
        if (clr_q && !go_q) begin
          fault_d = 1'b0;
          idx_d   = '0;
          timer_d = '0;
          state_d = S_OFF;
        end
      end
      default: begin
        en_d    = '0;
        state_d = S_OFF;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_OFF;
      idx_q   <= '0;
      en_q    <= '0;
      timer_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      timer_q <= timer_d;
      fault_q <= fault_d;
    end
  end

  assign ldo_en_o  = en_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_ldo_power_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for ldo_power_sequencer: enable edges and bus read data are
// predicted when stimulus is issued and checked as the DUT produces them.
module tb_ldo_power_sequencer;
  localparam int          NLD  = 3;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          PGD  = 5;
`ifdef LDO_SEQ_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           stb = 1'b0, cyc_i = 1'b0, we = 1'b0;
  logic [3:0]     sel = 4'h0;
  logic [31:0]    adr = '0, dat = '0;
  logic           ack, irq;
  logic [31:0]    rdat;
  logic [NLD-1:0] pg = '0;
  logic [NLD-1:0] en;

  always #5 clk = ~clk;

  ldo_power_sequencer #(.NUM_LDO(NLD), .BASE_ADR(BASE), .DLY_W(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc_i),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .ldo_pg_i (pg),
    .ldo_en_o (en),
    .irq_o    (irq)
  );

  typedef struct { logic [7:0] val; int at; } en_exp_t;
  typedef struct { logic [7:0] off; logic [31:0] val; } rd_exp_t;

  en_exp_t        en_sb[$];
  rd_exp_t        rd_sb[$];
  int             cyc = 0;
  int             n_vec = 0;
  int             n_err = 0;
  logic           rd_active = 1'b0;
  logic [NLD-1:0] en_prev = '0;
  logic [NLD-1:0] pg_hold = '0;
  int             rise_at [NLD];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Power-good responder plus the scoreboard pop side, all sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < NLD; i++) begin
      if (en[i] && !en_prev[i]) rise_at[i] = cyc;
      if (!en[i]) pg[i] = 1'b0;
      else if (!pg_hold[i] && cyc == rise_at[i] + PGD) pg[i] = 1'b1;
    end
    if (en !== en_prev) begin
      if (en_sb.size() == 0) begin
        chk("en_unexpected", 32'(en), 32'(en_prev));
      end else begin
        en_exp_t e;
        e = en_sb.pop_front();
        chk("en_value", 32'(en), 32'(e.val));
        chk("en_cycle", cyc, e.at);
      end
      en_prev = en;
    end
    if (ack && rd_active) begin
      if (rd_sb.size() == 0) begin
        chk("rd_unexpected", 32'(ack), 32'd0);
      end else begin
        rd_exp_t r;
        r = rd_sb.pop_front();
        chk($sformatf("rd_off%02h", r.off), rdat, r.val);
      end
    end
  end

  task automatic push_en(input logic [7:0] v, input int at);
    en_exp_t e;
    e.val = v;
    e.at  = at;
    en_sb.push_back(e);
  endtask

  // Each step: pin returns PGD cycles after enable, 3 cycles to react, then max(d,1) settle.
  task automatic plan_up(input int t0, input int d, input int upto);
    int t;
    t = t0;
    for (int i = 0; i < upto; i++) begin
      push_en(8'((1 << (i + 1)) - 1), t);
      t = t + PGD + 3 + ((d == 0) ? 1 : d);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    int ack_at, n;
    ack_at = cyc + 1;
    adr = BASE | 32'(off); dat = d; sel = s; we = 1'b1; stb = 1'b1; cyc_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack && n < 8);
    chk($sformatf("wr_ack_off%02h", off), cyc, ack_at);
    stb = 1'b0; cyc_i = 1'b0; we = 1'b0; sel = 4'h0;
    @(negedge clk);
  endtask

  task automatic wb_read(input logic [7:0] off, input logic [31:0] exp);
    int n;
    rd_exp_t r;
    r.off = off;
    r.val = exp;
    rd_sb.push_back(r);
    adr = BASE | 32'(off); we = 1'b0; sel = 4'hF; stb = 1'b1; cyc_i = 1'b1; rd_active = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack && n < 8);
    if (!ack) begin
      chk("rd_ack", 32'(ack), 32'd1);
      rd_sb.delete();
    end
    @(negedge clk);
    chk("rd_ack_single", 32'(ack), 32'd0);
    chk("rd_dat_idle", rdat, 32'd0);
    stb = 1'b0; cyc_i = 1'b0; rd_active = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int a;
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    wb_read(8'h00, 32'h0);
    wb_read(8'h04, 32'h0100);
    wb_read(8'h08, 32'h1000);
    wb_read(8'h0C, 32'h0);

    // Byte-lane write touches only the selected byte.
    wb_write(8'h04, 32'h0000_AA04, 4'b0001);
    wb_read(8'h04, 32'h0104);
    wb_write(8'h04, 32'd4, 4'hF);
    wb_write(8'h08, 32'd100, 4'hF);

    // Power-up 001 -> 011 -> 111.
    a = cyc + 1;
    plan_up(a + 1, 4, NLD);
    wb_write(8'h00, 32'h5, 4'hF);
    wb_read(8'h00, IRQ_ON ? 32'h5 : 32'h1);
    wait_until(a + 40);
    chk("up_pending", en_sb.size(), 32'd0);
    wb_read(8'h0C, 32'h000C_0707);

    // Power-down 111 -> 011 -> 001 -> 000.
    a = cyc + 1;
    push_en(8'h3, a + 1);
    push_en(8'h1, a + 5);
    push_en(8'h0, a + 9);
    wb_write(8'h00, 32'h4, 4'hF);
    wait_until(a + 16);
    chk("dn_pending", en_sb.size(), 32'd0);
    wb_read(8'h0C, 32'h0);

    // Abort during UP_SETTLE of LDO 1.
    a = cyc + 1;
    plan_up(a + 1, 4, 2);
    wb_write(8'h00, 32'h5, 4'hF);
    wait_until(a + 21);
    push_en(8'h1, a + 23);
    push_en(8'h0, a + 27);
    wb_write(8'h00, 32'h4, 4'hF);
    wait_until(a + 34);
    chk("abort_pending", en_sb.size(), 32'd0);
    wb_read(8'h0C, 32'h0);

    // Power-good timeout on LDO 1.
    wb_write(8'h08, 32'd10, 4'hF);
    pg_hold = 3'b010;
    a = cyc + 1;
    push_en(8'h1, a + 1);
    push_en(8'h3, a + 13);
    push_en(8'h0, a + 23);
    wb_write(8'h00, 32'h5, 4'hF);
    wait_until(a + 22);
    chk("tmo_irq_before", 32'(irq), 32'd0);
    wait_until(a + 23);
    chk("tmo_irq", 32'(irq), 32'(IRQ_ON));
    wait_until(a + 26);
    chk("tmo_pending", en_sb.size(), 32'd0);
    wb_read(8'h0C, 32'h0016_0000);

    // CLR_FAULT with GO=1 is ignored; with GO=0 it returns to OFF.
    wb_write(8'h00, 32'h7, 4'hF);
    repeat (3) @(negedge clk);
    wb_read(8'h0C, 32'h0016_0000);
    chk("clr_go1_irq", 32'(irq), 32'(IRQ_ON));
    wb_write(8'h00, 32'h6, 4'hF);
    chk("clr_irq", 32'(irq), 32'd0);
    wb_read(8'h0C, 32'h0);
    wb_read(8'h00, IRQ_ON ? 32'h4 : 32'h0);
    pg_hold = '0;

    // Unmapped offset.
    wb_read(8'h1C, 32'h0);

    // Asynchronous reset with two LDOs enabled.
    wb_write(8'h08, 32'd100, 4'hF);
    a = cyc + 1;
    plan_up(a + 1, 4, 2);
    wb_write(8'h00, 32'h5, 4'hF);
    wait_until(a + 15);
    push_en(8'h0, a + 16);
    #2 rst = 1'b1;
    #1;
    chk("arst_en", 32'(en), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_dat", rdat, 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wb_read(8'h0C, 32'h0);
    wb_read(8'h00, 32'h0);
    wb_read(8'h04, 32'h0100);
    wb_read(8'h08, 32'h1000);

    repeat (4) @(negedge clk);
    chk("en_sb_empty", en_sb.size(), 32'd0);
    chk("rd_sb_empty", rd_sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ldo_power_sequencer.md
# ldo_power_sequencer

Wishbone-controlled power sequencer that drives the enable pins of the on-chip 1.8 V LDO instances in the user area and monitors their power-good feedback. It powers the regulators up in index order and down in reverse order, with a programmable settle delay between steps. A power-good timeout, or power-good lost while running, forces a safe shutdown. It sits directly upstream of the LDO macros: its `ldo_en_o` bits are the LDO `en` inputs, and the `ldo_pg_i` bits come from comparators on the LDO `vo` outputs.

## Interface
- `NUM_LDO`, default 3: number of sequenced regulators, range 1–8.
- `BASE_ADR`, default 32'h3000_0000: Wishbone base address; the block decodes `wbs_adr_i[31:5]` against it.
- `DLY_W`, default 16: width of the delay and timeout counters.

Ports:
- `wb_clk_i` in, 1: single clock for all logic.
- `wb_rst_i` in, 1: reset, asynchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in, 1 each: Wishbone classic strobe, cycle and write-enable.
- `wbs_sel_i` in, 4: byte selects, honoured on writes.
- `wbs_adr_i`, `wbs_dat_i` in, 32 each: address and write data.
- `wbs_ack_o` out, 1: transfer acknowledge.
- `wbs_dat_o` out, 32: read data.
- `ldo_pg_i` in, NUM_LDO: power-good inputs, asynchronous, passed through a 2-flop synchronizer.
- `ldo_en_o` out, NUM_LDO: LDO enables, registered.
- `irq_o` out, 1: fault interrupt.

## Operation
Registers, at byte offsets from `BASE_ADR`:
- 0x00 CTRL (R/W)
  - bit0 GO: 1 = power up, 0 = power down.
  - bit1 CLR_FAULT: write-1 pulse; always reads 0.
  - bit2 IE.
- 0x04 DELAY[DLY_W-1:0]: settle cycles. Reset value 0x0100. A value of 0 behaves as 1.
- 0x08 TIMEOUT[DLY_W-1:0]: power-good wait limit in cycles. Reset value 0x1000. A value of 0 disables the timeout.
- 0x0C STATUS (RO)
  - [7:0] `ldo_en_o`
  - [15:8] synchronized power-good
  - [16] busy
  - [17] fault
  - [20:18] state
- Any other offset: reads 0, writes are ignored, and the access is still acked.

FSM states and encodings: OFF=0, UP_PG=1, UP_SETTLE=2, ON=3, DN_SETTLE=4, FAULT=5. An index register `idx` tracks the current LDO.
- **OFF**
  - All enables are 0.
  - If GO=1 and fault=0: set `en[0]=1`, `idx=0`, clear the timer, go to UP_PG.
- **UP_PG**
  - If `pg_sync[idx]=1`: clear the timer and go to UP_SETTLE.
  - Otherwise, if TIMEOUT≠0 and the timer reaches TIMEOUT: go to FAULT.
- **UP_SETTLE**
  - Wait DELAY cycles.
  - Then, if `idx=NUM_LDO-1`, go to ON.
  - Otherwise: `idx++`, set `en[idx]=1`, go to UP_PG.
- **ON**
  - If any `pg_sync` bit of an enabled LDO is 0: go to FAULT.
  - Otherwise, if GO=0: clear `en[idx]` and go to DN_SETTLE.
- **DN_SETTLE**
  - Wait DELAY cycles.
  - Then, if `idx=0`, go to OFF.
  - Otherwise: `idx--`, clear `en[idx]`, restart the wait.
- **GO cleared during UP_PG or UP_SETTLE**
  - Clear `en[idx]` and go to DN_SETTLE.
  - The in-progress up-step is abandoned.
- **FAULT**
  - Entry: all enables clear in the same cycle; fault=1, sticky.
  - Exit: CLR_FAULT written while GO=0 moves to OFF and clears fault.
  - CLR_FAULT written while GO=1 is ignored.
- **busy**: 1 in UP_PG, UP_SETTLE and DN_SETTLE.
- **Counters**: saturate, never wrap.

## Timing
- Reset values:
  - `ldo_en_o=0`, `wbs_ack_o=0`, `wbs_dat_o=0`, `irq_o=0`.
  - State OFF, `idx=0`, fault=0, CTRL=0.
  - Synchronizer flops cleared.
- Wishbone:
  - `wbs_ack_o` pulses for one cycle, the cycle after `stb&cyc` is seen with ack low.
  - Ack is never asserted in two consecutive cycles.
  - Write data takes effect on the ack edge.
  - Read data is valid while ack is high and 0 otherwise.
- GO=1 write → `en[0]` rises 1 cycle after ack.
- A power-good edge at the pin → FSM reacts 3 cycles later (2 synchronizer flops plus 1 FSM cycle).
- Settle time is exactly max(DELAY,1) cycles from the UP_SETTLE or DN_SETTLE entry edge to the next enable change.
- Timeout: FAULT is entered exactly TIMEOUT cycles after UP_PG entry when power-good stays low.
- Power-good loss in ON → all enables low 3 cycles after the pin edge.

## Configuration
- Macro `LDO_SEQ_IRQ_EN`:
  - Defined: `irq_o` is registered (fault & IE) and clears 1 cycle after CLR_FAULT is accepted.
  - Undefined: `irq_o` is tied 0, CTRL.IE reads 0 and writes to it are ignored.
  - All other behaviour is identical in both builds.

## Test plan
- **Reset:** assert `wb_rst_i` mid-sequence with 2 LDOs enabled → `ldo_en_o=0`, STATUS=0 immediately, with no clock edge required.
- **Power-up:** DELAY=4, TIMEOUT=100, GO=1, each `ldo_pg_i` bit returned 5 cycles after its enable → enables 001, 011, 111 at the specified spacing; STATUS.state=3; busy=0.
- **Power-down:** GO=0 from ON with DELAY=4 → 111, 011, 001, 000, with 4 cycles between changes; state=0.
- **Timeout:** TIMEOUT=10, `ldo_pg_i[1]` held low → FAULT 10 cycles after UP_PG entry for LDO 1; `ldo_en_o=0`; fault=1; `irq_o=1` when IE=1 and `LDO_SEQ_IRQ_EN` is defined.
- **Fault clear:** CLR_FAULT written with GO=1 → still FAULT; written again with GO=0 → OFF, fault=0, `irq_o=0`.
- **Abort and bus:** GO cleared during UP_SETTLE of LDO 1 → reverse ramp from 011 to 000. A read of offset 0x1C → data 0, single-cycle ack.
